// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter slice.
// State encodings, default widths and port ids.
package ram_arbiter_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  typedef logic port_t;

  localparam port_t P0 = 1'b0;
  localparam port_t P1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Masked ports are ignored; ties go to the port that lost last time.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  port_t      last_grant,
  output logic       grant_valid,
  output port_t      grant_id
);

  logic [1:0] elig;

  assign elig = req & ~mask;

  // pick the winner among eligible ports
  always_comb begin
    grant_valid = |elig;
    grant_id    = P0;
    unique case (1'b1)
      (elig == 2'b11): grant_id = ~last_grant;
      (elig == 2'b10): grant_id = P1;
      (elig == 2'b01): grant_id = P0;
      default:         grant_id = P0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for a single-port RAM.
// IDLE -> ACCESS -> RESP, one access per three cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          ram_w,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  logic [1:0] state;
  port_t      last_grant;
  port_t      lat_id;
  logic       lat_we;

  logic          gv;
  port_t         gid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic          in_resp;

  rr_arb2 u_arb (
    .req         ({req1, req0}),
    .mask        ({ack1, ack0}),
    .last_grant  (last_grant),
    .grant_valid (gv),
    .grant_id    (gid)
  );

  // steer the winning port's fields toward the latches
  always_comb begin
    sel_we   = we0;
    sel_addr = addr0;
    sel_din  = din0;
    unique case (1'b1)
      (gid == P1): begin
        sel_we   = we1;
        sel_addr = addr1;
        sel_din  = din1;
      end
      default: ;
    endcase
  end

  // sequencer state and latched transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= P1;
      lat_id     <= P0;
      lat_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gv) begin
            state      <= S_ACCESS;
            last_grant <= gid;
            lat_id     <= gid;
            lat_we     <= sel_we;
            ram_addr   <= sel_addr;
            ram_din    <= sel_din;
          end
        end
        S_ACCESS: state <= S_RESP;
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign in_resp = (state == S_RESP);

  // completion pulses and read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= in_resp && (lat_id == P0);
      ack1 <= in_resp && (lat_id == P1);
      if (in_resp && !lat_we && lat_id == P0)
        rdata0 <= ram_dout;
      if (in_resp && !lat_we && lat_id == P1)
        rdata1 <= ram_dout;
    end
  end

  // write only in ACCESS, and never while reset is asserted
  assign ram_w = lat_we & (state == S_ACCESS) & ~rst;

  assign busy = (state != S_IDLE);

endmodule
